// File: rtl/max7219_pkg.sv
// Shared constants, FSM state type and init ROM for the MAX7219 command scheduler.
package max7219_pkg;

  localparam logic [7:0] RegNoop      = 8'h00;
  localparam logic [7:0] RegDecode    = 8'h09;
  localparam logic [7:0] RegIntensity = 8'h0A;
  localparam logic [7:0] RegScanLimit = 8'h0B;
  localparam logic [7:0] RegShutdown  = 8'h0C;
  localparam logic [7:0] RegTest      = 8'h0F;

  localparam int unsigned InitLen = 6;

  typedef enum logic [1:0] {StInit, StIdle, StSend} state_e;

  // Start shut down, configure, leave test mode, then wake the display last.
  function automatic logic [15:0] init_rom(input logic [2:0] idx,
                                           input logic [2:0] scan_limit,
                                           input logic [3:0] intensity,
                                           input logic [7:0] decode);
    logic [15:0] word;
    case (idx)
      3'd0:    word = {RegShutdown, 8'h00};
      3'd1:    word = {RegScanLimit, 5'b0, scan_limit};
      3'd2:    word = {RegDecode, decode};
      3'd3:    word = {RegIntensity, 4'b0, intensity};
      3'd4:    word = {RegTest, 8'h00};
      3'd5:    word = {RegShutdown, 8'h01};
      default: word = {RegNoop, 8'h00};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/max7219_fifo_sched.sv
// Read-side FIFO controller: plays the MAX7219 init sequence, then drains FIFO
// words to the serializer over a valid/ready handshake.
module max7219_fifo_sched
  import max7219_pkg::*;
#(
  parameter logic [2:0] SCAN_LIMIT = 3'd7,
  parameter logic [3:0] INTENSITY  = 4'd8,
  parameter logic [7:0] DECODE     = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fifo_empty,
  input  logic [15:0] i_fifo_data,
  output logic        o_fifo_rd,
  output logic        o_tx_valid,
  output logic [15:0] o_tx_data,
  input  logic        i_tx_ready,
  input  logic        i_reinit,
  output logic        o_init_done,
  output logic        o_busy
);

  state_e      r_state, w_state_next;
  logic [2:0]  r_idx, w_idx_next;
  logic        r_tx_valid, w_tx_valid_next;
  logic [15:0] r_tx_data, w_tx_data_next;
  logic        r_init_done, w_init_done_next;
  logic        r_busy;
  logic        r_reinit_pend, w_reinit_pend_next;
  logic        w_accept, w_reinit, w_fifo_rd;

  assign w_accept = r_tx_valid & i_tx_ready;
  // A request arriving in the same cycle as the decision point is honoured immediately.
  assign w_reinit = r_reinit_pend | i_reinit;

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_tx_valid_next    = r_tx_valid;
    w_tx_data_next     = r_tx_data;
    w_init_done_next   = r_init_done;
    w_reinit_pend_next = w_reinit;
    w_fifo_rd          = 1'b0;
    unique case (r_state)
      StInit: begin
        if (!r_tx_valid) begin
          w_tx_valid_next = 1'b1;
          w_tx_data_next  = init_rom(r_idx, SCAN_LIMIT, INTENSITY, DECODE);
        end else if (w_accept) begin
          if (w_reinit) begin
            w_idx_next         = 3'd0;
            w_tx_data_next     = init_rom(3'd0, SCAN_LIMIT, INTENSITY, DECODE);
            w_reinit_pend_next = 1'b0;
            w_init_done_next   = 1'b0;
          end else if (r_idx == 3'(InitLen - 1)) begin
            w_state_next     = StIdle;
            w_tx_valid_next  = 1'b0;
            w_init_done_next = 1'b1;
          end else begin
            w_idx_next     = r_idx + 3'd1;
            w_tx_data_next = init_rom(r_idx + 3'd1, SCAN_LIMIT, INTENSITY, DECODE);
          end
        end
      end
      StIdle, StSend: begin
        if (r_state == StIdle || w_accept) begin
          if (w_reinit) begin
            w_state_next       = StInit;
            w_idx_next         = 3'd0;
            w_tx_valid_next    = 1'b1;
            w_tx_data_next     = init_rom(3'd0, SCAN_LIMIT, INTENSITY, DECODE);
            w_reinit_pend_next = 1'b0;
            w_init_done_next   = 1'b0;
          end else if (!i_fifo_empty) begin
            w_fifo_rd       = 1'b1;
            w_state_next    = StSend;
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = i_fifo_data;
          end else begin
            w_state_next    = StIdle;
            w_tx_valid_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next    = StInit;
        w_idx_next      = 3'd0;
        w_tx_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StInit;
      r_idx         <= 3'd0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 16'h0000;
      r_init_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_reinit_pend <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_tx_valid    <= w_tx_valid_next;
      r_tx_data     <= w_tx_data_next;
      r_init_done   <= w_init_done_next;
      r_busy        <= (w_state_next != StIdle);
      r_reinit_pend <= w_reinit_pend_next;
    end
  end

  // Reset must never pop the FIFO.
  assign o_fifo_rd   = w_fifo_rd & ~i_rst;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;
  assign o_init_done = r_init_done;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_max7219_fifo_sched.sv
// Directed bench for max7219_fifo_sched with a FIFO model and a word scoreboard.
module tb_max7219_fifo_sched;

  logic        clk = 1'b0;
  logic        i_rst, i_fifo_empty, i_tx_ready, i_reinit;
  logic [15:0] i_fifo_data;
  logic        o_fifo_rd, o_tx_valid, o_init_done, o_busy;
  logic [15:0] o_tx_data;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] init_words[6] = '{16'h0C00, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00, 16'h0C01};
  int          n_checks = 0, n_pass = 0, n_acc = 0, n_pops = 0;
  int          base_acc, base_pops;
  bit          pop_open = 1'b0, done_next = 1'b0, rd_seen = 1'b0;
  logic [15:0] w;

  always #5 clk = ~clk;

  max7219_fifo_sched #(
    .SCAN_LIMIT(3'd7),
    .INTENSITY (4'd8),
    .DECODE    (8'h00)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data (i_fifo_data),
    .o_fifo_rd   (o_fifo_rd),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .i_reinit    (i_reinit),
    .o_init_done (o_init_done),
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic upd_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
  endtask

  task automatic push_word(input logic [15:0] word);
    fifo_q.push_back(word);
    exp_q.push_back(word);
    upd_fifo();
  endtask

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back(init_words[i]);
  endtask

  // Samples outputs mid-cycle; accepted words are popped from the scoreboard.
  task automatic monitor();
    logic [15:0] e;
    rd_seen = o_fifo_rd;
    if (i_rst) begin
      pop_open  = 1'b0;
      done_next = 1'b0;
      return;
    end
    if (done_next) begin
      check("init_done_rise", o_init_done, 1);
      done_next = 1'b0;
    end
    if (o_tx_valid && i_tx_ready) begin
      n_acc++;
      pop_open = 1'b0;
      if (exp_q.size() == 0) begin
        check("sb_underflow_word", {16'h0, o_tx_data}, 32'h1_0000);
      end else begin
        e = exp_q.pop_front();
        check("tx_word", o_tx_data, e);
        if (e == 16'h0C00 || e == 16'h0C01) check("init_done_low", o_init_done, 0);
        if (e == 16'h0C01) done_next = 1'b1;
      end
    end
    if (o_fifo_rd) begin
      n_pops++;
      check("rd_nonempty", i_fifo_empty, 0);
      check("rd_no_double", pop_open, 0);
      pop_open = 1'b1;
    end
  endtask

  // One cycle: monitor at negedge, FIFO pops just after posedge, stimulus resumes 2 units in.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      upd_fifo();
    end
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin
    i_rst = 1'b1; i_tx_ready = 1'b0; i_reinit = 1'b0;
    upd_fifo();
    step(); step();
    check("rst_valid", o_tx_valid, 0);
    check("rst_data", o_tx_data, 16'h0000);
    check("rst_done", o_init_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rd", o_fifo_rd, 0);

    // Init sequence with ready held high.
    i_rst = 1'b0; i_tx_ready = 1'b1;
    push_init();
    base_pops = n_pops; base_acc = n_acc;
    step();
    check("first_valid", o_tx_valid, 1);
    check("first_word", o_tx_data, 16'h0C00);
    check("init_busy", o_busy, 1);
    drain(20);
    check("init_accepts", n_acc - base_acc, 6);
    check("init_no_pop", n_pops - base_pops, 0);
    check("init_done", o_init_done, 1);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_tx_valid, 0);

    // Three words back to back.
    base_pops = n_pops; base_acc = n_acc;
    push_word(16'h0155); push_word(16'h02AA); push_word(16'h0381);
    #1;
    check("idle_pop", o_fifo_rd, 1);
    step();
    check("b2b_valid", o_tx_valid, 1);
    check("b2b_first", o_tx_data, 16'h0155);
    check("send_busy", o_busy, 1);
    step();
    check("b2b_acc1", n_acc - base_acc, 1);
    step();
    check("b2b_acc2", n_acc - base_acc, 2);
    step();
    check("b2b_acc3", n_acc - base_acc, 3);
    check("b2b_pops", n_pops - base_pops, 3);
    check("b2b_valid_low", o_tx_valid, 0);

    // Backpressure.
    i_tx_ready = 1'b0;
    base_pops = n_pops; base_acc = n_acc;
    push_word(16'h0155); push_word(16'h02AA);
    #1;
    check("bp_pop", o_fifo_rd, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", o_tx_data, 16'h0155);
      check("bp_hold_valid", o_tx_valid, 1);
      check("bp_no_extra_pop", n_pops - base_pops, 1);
      step();
    end
    i_tx_ready = 1'b1;
    step();
    i_tx_ready = 1'b0;
    check("bp_one_accept", n_acc - base_acc, 1);
    check("bp_next_word", o_tx_data, 16'h02AA);
    check("bp_pops", n_pops - base_pops, 2);

    // Reinit while 0x02AA is held.
    i_reinit = 1'b1;
    step();
    i_reinit = 1'b0;
    push_init();
    push_word(16'h0381);
    check("ri_done_before", o_init_done, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ri_hold", o_tx_data, 16'h02AA);
    end
    i_tx_ready = 1'b1;
    drain(40);
    check("ri_done_after", o_init_done, 1);
    check("ri_pops", n_pops - base_pops, 3);
    check("ri_valid_low", o_tx_valid, 0);

    // Reset in the middle of init.
    i_rst = 1'b1; i_tx_ready = 1'b0;
    exp_q.delete();
    step();
    check("rst2_done", o_init_done, 0);
    i_rst = 1'b0; i_tx_ready = 1'b1;
    push_init();
    base_acc = n_acc;
    for (int i = 0; i < 20 && n_acc - base_acc < 3; i++) step();
    check("reach_idx3", n_acc - base_acc, 3);
    check("idx3_word", o_tx_data, 16'h0A08);
    i_rst = 1'b1; i_tx_ready = 1'b0;
    exp_q.delete();
    step();
    check("mid_rst_valid", o_tx_valid, 0);
    check("mid_rst_done", o_init_done, 0);
    check("mid_rst_busy", o_busy, 0);
    i_rst = 1'b0; i_tx_ready = 1'b1;
    push_init();
    step();
    check("restart_word", o_tx_data, 16'h0C00);
    drain(20);
    check("restart_done", o_init_done, 1);

    // Sparse arrivals, one word every 4 cycles.
    base_pops = n_pops;
    for (int k = 0; k < 5; k++) begin
      w = 16'h1100 + 16'(k) * 16'h0111;
      push_word(w);
      #1;
      check("sparse_pop", o_fifo_rd, 1);
      step();
      check("sparse_valid", o_tx_valid, 1);
      check("sparse_word", o_tx_data, w);
      step(); step(); step();
    end
    check("sparse_pops", n_pops - base_pops, 5);
    check("sparse_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
